// File: rtl/store_align_unit.sv
// rtl/store_align_unit.sv - store lane alignment, in-order store queue and memory write issue
module store_align_unit #(
    parameter int DEPTH = 2,
    parameter int AW    = 64,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    input  logic [1:0]    st_size,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic          mem_ack,
    output logic          misalign,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hazard,
    output logic          busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NB = DW / 8;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t state, next_state;

    // Queue storage and pointers; pointers carry one extra bit to tell full from empty
    logic [AW-1:0] q_addr  [DEPTH];
    logic [DW-1:0] q_wdata [DEPTH];
    logic [7:0]    q_wmask [DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr;
    logic [PW:0]   wr_next, rd_next;
    logic [PW:0]   count, nxt_count;
    logic          full;

    // Aligned form of the incoming request
    logic [7:0]    base_mask;
    logic [DW-1:0] keep_bits;
    logic          mis;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic [7:0]    in_mask;

    logic          accept, push, pop;
    logic          bypass;
    logic          load, clear;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_wdata;
    logic [7:0]    head_wmask;
    logic [AW-1:0] ld_line;
    logic [PW-1:0] slot;

    // Size decode: byte-enable pattern, misalignment test and lane shift of the request
    always_comb begin
        base_mask = 8'h00;
        mis       = 1'b0;
        case (st_size)
            2'b00: base_mask = 8'h01;
            2'b01: begin
                base_mask = 8'h03;
                mis       = st_addr[0];
            end
            2'b10: begin
                base_mask = 8'h0F;
                mis       = |st_addr[1:0];
            end
            default: begin
                base_mask = 8'hFF;
                mis       = |st_addr[2:0];
            end
        endcase
        keep_bits = '0;
        for (int b = 0; b < NB; b++) begin
            keep_bits[8*b +: 8] = {8{base_mask[b]}};
        end
        in_mask = base_mask << st_addr[2:0];
        in_data = (st_data & keep_bits) << {st_addr[2:0], 3'b000};
        in_addr = {st_addr[AW-1:3], 3'b000};
    end

    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == (PW+1)'(DEPTH));
    assign st_ready = !full;
    assign busy     = (count != '0);
    assign accept   = st_valid && st_ready;
    assign push     = accept && !mis;
    assign pop      = (state == ISSUE) && mem_ack;
    assign mem_req  = (state == ISSUE);

    assign wr_next   = wr_ptr + {{PW{1'b0}}, push};
    assign rd_next   = rd_ptr + {{PW{1'b0}}, pop};
    assign nxt_count = wr_next - rd_next;

    // The entry presented next cycle is the incoming request when the queue would otherwise be empty
    assign bypass     = push && (rd_next[PW-1:0] == wr_ptr[PW-1:0]);
    assign head_addr  = bypass ? in_addr : q_addr[rd_next[PW-1:0]];
    assign head_wdata = bypass ? in_data : q_wdata[rd_next[PW-1:0]];
    assign head_wmask = bypass ? in_mask : q_wmask[rd_next[PW-1:0]];

    // Queue entry write on push
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr[PW-1:0]]  <= in_addr;
            q_wdata[wr_ptr[PW-1:0]] <= in_data;
            q_wmask[wr_ptr[PW-1:0]] <= in_mask;
        end
    end

    // Queue pointers advance on push and on acknowledged pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
        end
    end

    // Misalignment pulse for the cycle after a dropped request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign <= 1'b0;
        end else begin
            misalign <= accept && mis;
        end
    end

    // Issue FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Issue FSM next state: present a new head whenever the queue will hold one
    always_comb begin
        next_state = state;
        load       = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (nxt_count != '0) begin
                    next_state = ISSUE;
                    load       = 1'b1;
                end
            end
            ISSUE: begin
                if (pop) begin
                    if (nxt_count != '0) begin
                        load = 1'b1;
                    end else begin
                        next_state = IDLE;
                        clear      = 1'b1;
                    end
                end
            end
        endcase
    end

    // Registered write port fields, held stable until acknowledged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else if (load) begin
            mem_addr  <= head_addr;
            mem_wdata <= head_wdata;
            mem_wmask <= head_wmask;
        end else if (clear) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end
    end

    assign ld_line = {ld_addr[AW-1:3], 3'b000};

    // Load hazard: any live queue slot whose line matches the load's line
    always_comb begin
        ld_hazard = 1'b0;
        slot      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = PW'(i) - rd_ptr[PW-1:0];
            if (({1'b0, slot} < count) && (q_addr[i] == ld_line)) begin
                ld_hazard = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_align_unit.sv
// tb/tb_store_align_unit.sv - self-checking bench for store_align_unit
module tb_store_align_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [63:0] st_addr = '0;
    logic [63:0] st_data = '0;
    logic [1:0]  st_size = '0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ack = 1'b0;
    logic        misalign;
    logic [63:0] ld_addr = '0;
    logic        ld_hazard;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
    } wr_t;

    wr_t  q[$];
    logic exp_mis = 1'b0;

    store_align_unit #(.DEPTH(DEPTH), .AW(64), .DW(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_size   (st_size),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_ack   (mem_ack),
        .misalign  (misalign),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_misaligned(input logic [63:0] a, input logic [1:0] sz);
        int n;
        n = 1 << sz;
        return (a % 64'(n)) != 0;
    endfunction

    function automatic wr_t expected_write(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz);
        wr_t          w;
        int           n;
        int           off;
        logic [127:0] m;
        logic [127:0] dm;
        n      = 1 << sz;
        off    = int'(a % 8);
        m      = ((128'd1 << n) - 128'd1) << off;
        dm     = ({64'd0, d} & ((128'd1 << (8 * n)) - 128'd1)) << (8 * off);
        w.addr = a - (a % 8);
        w.mask = m[7:0];
        w.data = dm[63:0];
        return w;
    endfunction

    // Compare every output with the model, then advance model and DUT by one clock
    task automatic step();
        logic hz;
        bit   acc;
        #1;
        hz = 1'b0;
        foreach (q[i]) if (q[i].addr == ld_addr - (ld_addr % 8)) hz = 1'b1;
        chk("st_ready", st_ready, q.size() < DEPTH);
        chk("mem_req", mem_req, q.size() != 0);
        chk("busy", busy, q.size() != 0);
        chk("ld_hazard", ld_hazard, hz);
        chk("misalign", misalign, exp_mis);
        if (q.size() != 0) begin
            chk("mem_addr", mem_addr, q[0].addr);
            chk("mem_wdata", mem_wdata, q[0].data);
            chk("mem_wmask", mem_wmask, q[0].mask);
        end
        acc = st_valid && (q.size() < DEPTH);
        if (mem_ack && q.size() != 0) void'(q.pop_front());
        exp_mis = acc && is_misaligned(st_addr, st_size);
        if (acc && !is_misaligned(st_addr, st_size))
            q.push_back(expected_write(st_addr, st_data, st_size));
        @(negedge clk);
    endtask

    task automatic store_ack(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz,
                             input logic [7:0] em, input logic [63:0] ed, input string tag);
        st_valid = 1'b1; st_addr = a; st_data = d; st_size = sz;
        step();
        st_valid = 1'b0;
        #1;
        chk({tag, "_req"}, mem_req, 1'b1);
        chk({tag, "_addr"}, mem_addr, a - (a % 8));
        chk({tag, "_wmask"}, mem_wmask, em);
        chk({tag, "_wdata"}, mem_wdata, ed);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        #1;
        chk({tag, "_req_done"}, mem_req, 1'b0);
        chk({tag, "_busy_done"}, busy, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_mem_wmask", mem_wmask, 8'd0);
        chk("rst_misalign", misalign, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_st_ready", st_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Byte, half, word and dword alignment
        store_ack(64'h8000_0005, 64'hAABB_CCDD_EEFF_1122, 2'b00, 8'h20, 64'h0000_2200_0000_0000, "byte");
        store_ack(64'h8000_0006, 64'h0000_0000_0000_1234, 2'b01, 8'hC0, 64'h1234_0000_0000_0000, "half");
        store_ack(64'h8000_0004, 64'h0000_0000_DEAD_BEEF, 2'b10, 8'hF0, 64'hDEAD_BEEF_0000_0000, "word");
        store_ack(64'h8000_0010, 64'h0123_4567_89AB_CDEF, 2'b11, 8'hFF, 64'h0123_4567_89AB_CDEF, "dword");

        // Misaligned word is consumed and dropped
        st_valid = 1'b1; st_addr = 64'h8000_0002; st_data = 64'h1111_2222; st_size = 2'b10;
        step();
        st_valid = 1'b0;
        #1;
        chk("mis_pulse", misalign, 1'b1);
        chk("mis_ready", st_ready, 1'b1);
        chk("mis_req", mem_req, 1'b0);
        step();
        chk("mis_pulse_end", misalign, 1'b0);
        chk("mis_busy", busy, 1'b0);

        // Back-pressure with DEPTH entries outstanding
        st_valid = 1'b1; st_addr = 64'h2000; st_data = 64'hA0A0; st_size = 2'b11;
        step();
        st_addr = 64'h2008; st_data = 64'hB0B0;
        step();
        st_addr = 64'h2010; st_data = 64'hC0C0;
        #1;
        chk("bp_full", st_ready, 1'b0);
        step();
        step();
        chk("bp_head_a", mem_addr, 64'h2000);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        #1;
        chk("bp_head_b", mem_addr, 64'h2008);
        chk("bp_ready_after_ack", st_ready, 1'b1);
        step();
        st_valid = 1'b0;
        chk("bp_still_b", mem_addr, 64'h2008);
        mem_ack = 1'b1;
        step();
        chk("bp_head_c", mem_addr, 64'h2010);
        step();
        mem_ack = 1'b0;
        chk("bp_drained", busy, 1'b0);

        // Load/store line hazard
        st_valid = 1'b1; st_addr = 64'h1008; st_data = 64'h5555; st_size = 2'b11;
        step();
        st_valid = 1'b0;
        ld_addr = 64'h100C;
        #1;
        chk("hz_same_line", ld_hazard, 1'b1);
        ld_addr = 64'h1010;
        #1;
        chk("hz_next_line", ld_hazard, 1'b0);
        ld_addr = 64'h100C;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        #1;
        chk("hz_after_ack", ld_hazard, 1'b0);

        // Asynchronous reset with two entries and a write in flight
        st_valid = 1'b1; st_addr = 64'h3000; st_data = 64'h77; st_size = 2'b11;
        step();
        st_addr = 64'h3008;
        step();
        st_valid = 1'b0;
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req", mem_req, 1'b0);
        chk("arst_addr", mem_addr, 64'd0);
        chk("arst_wdata", mem_wdata, 64'd0);
        chk("arst_wmask", mem_wmask, 8'd0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ready", st_ready, 1'b1);
        q.delete();
        exp_mis = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) step();

        // Random traffic against the queue model
        repeat (400) begin
            st_valid = 1'($urandom_range(0, 1));
            st_addr  = 64'h1000 + 64'($urandom_range(0, 47));
            st_data  = {$urandom, $urandom};
            st_size  = 2'($urandom_range(0, 3));
            mem_ack  = ($urandom_range(0, 2) != 0);
            ld_addr  = 64'h1000 + 64'($urandom_range(0, 47));
            step();
        end
        st_valid = 1'b0;
        mem_ack  = 1'b1;
        repeat (DEPTH + 2) step();
        mem_ack = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/store_align_unit.md
Name: store_align_unit

Overview:
- Write-side counterpart of the execute stage's load extraction path.
- Accepts store requests (address, 64-bit register data, size) from the execute stage and converts each one into an 8-byte-aligned memory write: lane-shifted data plus a byte mask.
- Buffers requests in a small in-order queue and issues them to the data memory port with a req/ack handshake.
- Flags misaligned stores and reports load/store address hazards to the load path.

Parameters:
- DEPTH, 2: store queue entries; power of two, minimum 2.
- AW, 64: address width.
- DW, 64: data width (fixed at 64; the byte mask is DW/8 bits).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- st_valid  in  1  store request valid.
- st_ready  out  1  queue can accept a request.
- st_addr  in  AW  byte address of the store.
- st_data  in  DW  source register value; low bytes are significant.
- st_size  in  2  00 = byte, 01 = half, 10 = word, 11 = dword.
- mem_req  out  1  write request to memory.
- mem_addr  out  AW  8-byte-aligned write address.
- mem_wdata  out  DW  lane-aligned write data.
- mem_wmask  out  8  byte-enable mask.
- mem_ack  in  1  memory accepted the current write.
- misalign  out  1  one-cycle pulse: a misaligned store was consumed and dropped.
- ld_addr  in  AW  address of the load in execute.
- ld_hazard  out  1  a pending store covers the same 8-byte line as ld_addr.
- busy  out  1  queue non-empty.

Behaviour:
- Reset (rst = 0, asynchronous):
  - Queue empty, pointers = 0, FSM = IDLE.
  - Outputs: mem_req = 0, mem_addr = 0, mem_wdata = 0, mem_wmask = 0, misalign = 0, busy = 0, st_ready = 1.
  - A reset mid-handshake discards all entries; an in-flight write is abandoned.
- Accept: a request is consumed on a rising edge with st_valid && st_ready.
  - st_ready = !full.
  - When full, no push occurs even if a pop happens in the same cycle.
- Misalignment test at accept:
  - half: addr[0] != 0.
  - word: addr[1:0] != 0.
  - dword: addr[2:0] != 0.
  - A misaligned request is consumed but not enqueued; misalign = 1 for exactly the following cycle.
- Alignment, computed at accept and stored per entry. With off = st_addr[2:0]:
  - addr_q = {st_addr[AW-1:3], 3'b000}.
  - base mask: byte 0x01, half 0x03, word 0x0F, dword 0xFF.
  - wmask = base << off, truncated to 8 bits.
  - wdata = (st_data with bytes outside the size zeroed) << (8*off). Unused lanes are 0.
- FSM:
  - IDLE: mem_req = 0; go to ISSUE when the queue is non-empty.
  - ISSUE: mem_req = 1 and mem_addr/wdata/wmask = head entry, registered and held stable until mem_ack.
  - On mem_ack in ISSUE: pop the head. Stay in ISSUE with the next entry presented from the next cycle, or go to IDLE if the queue becomes empty.
  - mem_ack while mem_req = 0 is ignored.
- Latency: a store accepted into an empty queue raises mem_req on the next cycle.
- Ordering: strict FIFO. Pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.
- Simultaneous push and pop (not full): both occur; count is unchanged.
- ld_hazard (combinational):
  - 1 if any valid queued entry has addr_q == {ld_addr[AW-1:3], 3'b000}, including the head during ISSUE.
  - An entry stops matching on the cycle after its mem_ack.
- busy = count != 0.

Test Plan:
1. Byte store: addr 0x8000_0005, data 0xAABB_CCDD_EEFF_1122, size 00 -> next cycle mem_req = 1, mem_addr = 0x8000_0000, mem_wmask = 0x20, mem_wdata = 0x0000_2200_0000_0000; ack -> mem_req = 0, busy = 0.
2. Half/word/dword alignment:
   - half at 0x...06, data 0x1234 -> wmask 0xC0, wdata 0x1234_0000_0000_0000.
   - word at 0x...04, data 0xDEADBEEF -> wmask 0xF0, wdata 0xDEADBEEF_0000_0000.
   - dword at 0x...00 -> wmask 0xFF, wdata equal to the data.
3. Misaligned word at 0x...02 -> st_ready stays 1, misalign pulses 1 cycle, mem_req never rises, busy = 0.
4. Back-pressure:
   - Push 3 stores with mem_ack held 0 and DEPTH = 2 -> st_ready = 0 after 2 stores; the third is held.
   - Ack -> the third is accepted one cycle later.
   - Writes issue in push order; mem_* outputs are stable while unacked.
5. Hazard: store queued at 0x1008; ld_addr = 0x100C -> ld_hazard = 1; ld_addr = 0x1010 -> 0; after ack of 0x1008 -> 0 for ld_addr = 0x100C.
6. Reset mid-operation: rst low while mem_req = 1 with 2 entries -> outputs 0 immediately (asynchronous); after release st_ready = 1, busy = 0, and no stale write is issued.
